// File: rtl/load_align_unit_pkg.sv
// load_pkg: size encodings, FSM states and the spanning-access test shared by the load path
package load_pkg;
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;
  typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP} state_t;
  function automatic logic spans(input int off, input logic [1:0] size, input int nb);
    return off + (1 << size) > nb;
  endfunction
endpackage

// File: rtl/load_align_unit_extend.sv
// load_extend: shifts two beats down to the byte offset, truncates to the access size and sign/zero-extends
module load_extend #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0]            beat0,
  input  logic [XLEN-1:0]            beat1,
  input  logic [$clog2(XLEN/8)-1:0]  offset,
  input  logic [1:0]                 size,
  input  logic                       uns,
  output logic [XLEN-1:0]            data
);
  logic [XLEN-1:0] lo;
  logic [XLEN-1:0] mask;
  logic [6:0]      nb;
  logic            sign;
  always_comb begin
    lo   = XLEN'({beat1, beat0} >> {offset, 3'b000});
    nb   = 7'd8 << size;
    mask = ~({XLEN{1'b1}} << nb);
    sign = ~uns & |(lo & mask & ~(mask >> 1));
    data = (lo & mask) | ({XLEN{sign}} & ~mask);
  end
endmodule

// File: rtl/load_align_unit.sv
// load_align_unit: one-in-flight aligned/misaligned load FSM; LOAD_MISALIGNED_SPLIT_EN enables two-beat spanning loads
module load_align_unit
  import load_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_rsp_valid,
  input  logic [XLEN-1:0]   mem_rsp_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [XLEN-1:0]   rsp_data,
  output logic              rsp_misaligned,
  output logic              rsp_fault
);
  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);
  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [XLEN-1:0]   ext_b0;
  logic [XLEN-1:0]   ext_b1;
  logic [XLEN-1:0]   ext_data;
  logic [ADDR_W-1:0] base;
  logic              req_fault;
  assign base          = {addr_q[ADDR_W-1:OW], {OW{1'b0}}};
  assign req_ready     = state == IDLE;
  assign mem_req_valid = state == REQ0 || state == REQ1;
  assign mem_req_addr  = base + (state == REQ1 ? ADDR_W'(NB) : ADDR_W'(0));
  assign rsp_valid     = state == RESP;
  assign req_fault     = XLEN == 32 && req_size == SZ_D;
`ifdef LOAD_MISALIGNED_SPLIT_EN
  logic [XLEN-1:0] beat0_q;
  logic            span_q;
  assign span_q = spans(int'(addr_q[OW-1:0]), size_q, NB);
  assign ext_b0 = state == WAIT1 ? beat0_q : mem_rsp_data;
  assign ext_b1 = state == WAIT1 ? mem_rsp_data : '0;
`else
  logic req_span;
  assign req_span = spans(int'(req_addr[OW-1:0]), req_size, NB);
  assign ext_b0   = mem_rsp_data;
  assign ext_b1   = '0;
`endif
  load_extend #(.XLEN(XLEN)) u_ext (
    .beat0  (ext_b0),
    .beat1  (ext_b1),
    .offset (addr_q[OW-1:0]),
    .size   (size_q),
    .uns    (uns_q),
    .data   (ext_data)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      addr_q         <= '0;
      size_q         <= '0;
      uns_q          <= 1'b0;
      rsp_data       <= '0;
      rsp_misaligned <= 1'b0;
      rsp_fault      <= 1'b0;
`ifdef LOAD_MISALIGNED_SPLIT_EN
      beat0_q        <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          addr_q    <= req_addr;
          size_q    <= req_size;
          uns_q     <= req_unsigned;
          rsp_data  <= '0;
          rsp_fault <= req_fault;
`ifdef LOAD_MISALIGNED_SPLIT_EN
          rsp_misaligned <= 1'b0;
          state          <= req_fault ? RESP : REQ0;
`else
          rsp_misaligned <= !req_fault && req_span;
          state          <= (req_fault || req_span) ? RESP : REQ0;
`endif
        end
        REQ0: if (mem_req_ready) state <= WAIT0;
        WAIT0: if (mem_rsp_valid) begin
`ifdef LOAD_MISALIGNED_SPLIT_EN
          if (span_q) begin
            beat0_q <= mem_rsp_data;
            state   <= REQ1;
          end else begin
            rsp_data <= ext_data;
            state    <= RESP;
          end
`else
          rsp_data <= ext_data;
          state    <= RESP;
`endif
        end
`ifdef LOAD_MISALIGNED_SPLIT_EN
        REQ1: if (mem_req_ready) state <= WAIT1;
        WAIT1: if (mem_rsp_valid) begin
          rsp_data <= ext_data;
          state    <= RESP;
        end
`endif
        RESP: if (rsp_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_load_align_unit.sv
// tb_load_align_unit: randomized loads against a byte-addressed memory model with directed corner cases
module tb_load_align_unit;
  localparam bit SPLIT =
`ifdef LOAD_MISALIGNED_SPLIT_EN
    1'b1;
`else
    1'b0;
`endif
  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_misaligned;
  logic        rsp_fault;
  int          total;
  int          bad;
  logic [7:0]  mem [0:511];
  load_align_unit dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr       (req_addr),
    .req_size       (req_size),
    .req_unsigned   (req_unsigned),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_data   (mem_rsp_data),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_data       (rsp_data),
    .rsp_misaligned (rsp_misaligned),
    .rsp_fault      (rsp_fault)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic logic [31:0] word_at(input logic [31:0] a);
    logic [8:0] b;
    b = {a[8:2], 2'b00};
    return {mem[b + 9'd3], mem[b + 9'd2], mem[b + 9'd1], mem[b]};
  endfunction
  function automatic logic [31:0] model(input logic [31:0] a, input logic [1:0] sz, input logic u);
    int n;
    logic [31:0] v;
    n = 1 << sz;
    v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = mem[a[8:0] + 9'(i)];
    if (!u && n < 4 && v[8*n-1]) for (int i = 8*n; i < 32; i++) v[i] = 1'b1;
    return v;
  endfunction
  task automatic run_load(input logic [31:0] a, input logic [1:0] sz, input logic u, input bit zw,
                          input int hold, output logic [31:0] got_d, output int lat);
    logic [31:0] exp_d;
    logic        exp_m;
    logic        exp_f;
    logic [31:0] exp_q[$];
    logic [31:0] cur;
    bit          span;
    bit          waiting;
    bit          done;
    int          wcnt;
    int          rcnt;
    int          cyc;
    exp_f = sz == 2'd3;
    span  = (int'(a[1:0]) + (1 << sz)) > 4;
    exp_m = !exp_f && span && !SPLIT;
    exp_d = (exp_f || exp_m) ? 32'h0 : model(a, sz, u);
    if (!exp_f && !exp_m) begin
      exp_q.push_back({a[31:2], 2'b00});
      if (span) exp_q.push_back({a[31:2], 2'b00} + 32'd4);
    end
    got_d = '0;
    lat = -1;
    cur = '0;
    waiting = 0;
    done = 0;
    wcnt = 0;
    rcnt = 0;
    cyc = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_addr = a;
    req_size = sz;
    req_unsigned = u;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    rsp_ready = 1'b0;
    total++;
    if (req_ready !== 1'b1) begin
      bad++;
      $display("FAIL req_ready_idle got=%b exp=1", req_ready);
    end
    while (!done && cyc < 60) begin
      @(negedge clk);
      cyc++;
      req_valid = 1'b0;
      mem_req_ready = 1'b0;
      rsp_ready = 1'b0;
      if (waiting) begin
        if (wcnt == 0) begin
          mem_rsp_valid = 1'b1;
          mem_rsp_data = word_at(cur);
          waiting = 0;
        end else begin
          mem_rsp_valid = 1'b0;
          wcnt--;
        end
      end else begin
        mem_rsp_valid = $urandom_range(0, 3) == 0;
        mem_rsp_data = $urandom;
      end
      if (mem_req_valid) begin
        total++;
        if (exp_q.size() == 0 || mem_req_addr !== exp_q[0]) begin
          bad++;
          $display("FAIL mem_req_addr got=%h exp=%h pending=%0d", mem_req_addr,
                   exp_q.size() != 0 ? exp_q[0] : 32'hx, exp_q.size());
        end
        mem_req_ready = zw ? 1'b1 : 1'($urandom);
        if (mem_req_ready) begin
          cur = mem_req_addr;
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          waiting = 1;
          wcnt = zw ? 0 : $urandom_range(0, 2);
        end
      end
      if (rsp_valid) begin
        rcnt++;
        if (rcnt == 1) begin
          got_d = rsp_data;
          lat = cyc;
          total += 3;
          if (rsp_data !== exp_d) begin
            bad++;
            $display("FAIL rsp_data addr=%h size=%0d uns=%b got=%h exp=%h", a, sz, u, rsp_data, exp_d);
          end
          if (rsp_misaligned !== exp_m) begin
            bad++;
            $display("FAIL rsp_misaligned addr=%h size=%0d got=%b exp=%b", a, sz, rsp_misaligned, exp_m);
          end
          if (rsp_fault !== exp_f) begin
            bad++;
            $display("FAIL rsp_fault addr=%h size=%0d got=%b exp=%b", a, sz, rsp_fault, exp_f);
          end
        end else begin
          total++;
          if (rsp_data !== got_d || rsp_misaligned !== exp_m || rsp_fault !== exp_f || req_ready !== 1'b0) begin
            bad++;
            $display("FAIL rsp_stable data=%h first=%h mis=%b flt=%b req_ready=%b exp_ready=0",
                     rsp_data, got_d, rsp_misaligned, rsp_fault, req_ready);
          end
        end
        rsp_ready = rcnt > hold;
        done = rsp_ready;
      end
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL timeout addr=%h size=%0d got=no_response exp=response", a, sz);
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL mem_req_count missing=%0d exp=0", exp_q.size());
    end
  endtask
  task automatic test_reset;
    rst = 1'b1;
    req_valid = 1'b0;
    req_addr = '0;
    req_size = '0;
    req_unsigned = 1'b0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data = '0;
    rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    for (int p = 0; p < 2; p++) begin
      total += 6;
      if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready p=%0d got=%b exp=1", p, req_ready); end
      if (mem_req_valid !== 1'b0) begin bad++; $display("FAIL reset_mem_req_valid p=%0d got=%b exp=0", p, mem_req_valid); end
      if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid p=%0d got=%b exp=0", p, rsp_valid); end
      if (rsp_misaligned !== 1'b0) begin bad++; $display("FAIL reset_misaligned p=%0d got=%b exp=0", p, rsp_misaligned); end
      if (rsp_fault !== 1'b0) begin bad++; $display("FAIL reset_fault p=%0d got=%b exp=0", p, rsp_fault); end
      if (rsp_data !== 32'h0) begin bad++; $display("FAIL reset_rsp_data p=%0d got=%h exp=0", p, rsp_data); end
      rst = 1'b0;
      @(negedge clk);
    end
  endtask
  task automatic test_directed;
    logic [31:0] d;
    int l;
    {mem[259], mem[258], mem[257], mem[256]} = 32'h80FF_1234;
    run_load(32'h103, 2'd0, 1'b0, 1'b1, 0, d, l);
    total++;
    if (d !== 32'hFFFF_FF80) begin bad++; $display("FAIL lb_0x103 got=%h exp=ffffff80", d); end
    {mem[259], mem[258], mem[257], mem[256]} = 32'hBEEF_0000;
    run_load(32'h102, 2'd1, 1'b1, 1'b1, 0, d, l);
    total += 2;
    if (d !== 32'h0000_BEEF) begin bad++; $display("FAIL lhu_0x102 got=%h exp=0000beef", d); end
    if (l !== 3) begin bad++; $display("FAIL lhu_latency got=%0d exp=3", l); end
    {mem[263], mem[262], mem[261], mem[260]} = 32'h5566_7788;
    {mem[267], mem[266], mem[265], mem[264]} = 32'h1122_3344;
    run_load(32'h106, 2'd2, 1'b0, 1'b1, 0, d, l);
    total++;
    if (d !== (SPLIT ? 32'h3344_5566 : 32'h0)) begin
      bad++;
      $display("FAIL lw_0x106 got=%h exp=%h", d, SPLIT ? 32'h3344_5566 : 32'h0);
    end
  endtask
  task automatic test_fault;
    logic [31:0] d;
    int l;
    for (int i = 0; i < 4; i++) run_load(32'($urandom_range(0, 'h1EF)), 2'd3, 1'($urandom), 1'b0, 0, d, l);
  endtask
  task automatic test_hold;
    logic [31:0] d;
    int l;
    run_load({23'h0, 7'($urandom), 2'b00}, 2'd2, 1'b0, 1'b0, 5, d, l);
    run_load(32'($urandom_range(0, 'h1EF)), 2'd0, 1'b0, 1'b0, 5, d, l);
  endtask
  task automatic test_reset_midflight;
    int beats;
    int k;
    logic [31:0] d;
    int l;
    beats = SPLIT ? 2 : 1;
    @(negedge clk);
    req_valid = 1'b1;
    req_addr = SPLIT ? 32'h106 : 32'h104;
    req_size = 2'd2;
    req_unsigned = 1'b0;
    mem_rsp_valid = 1'b0;
    rsp_ready = 1'b0;
    for (int b = 0; b < beats; b++) begin
      k = 0;
      do begin
        @(negedge clk);
        req_valid = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_req_ready = 1'b1;
        k++;
      end while (!mem_req_valid && k < 10);
      total++;
      if (mem_req_valid !== 1'b1) begin bad++; $display("FAIL midflight_mem_req beat=%0d got=%b exp=1", b, mem_req_valid); end
      @(negedge clk);
      mem_req_ready = 1'b0;
      if (b < beats - 1) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data = word_at(32'h104);
      end
    end
    rst = 1'b1;
    mem_rsp_valid = 1'b1;
    mem_rsp_data = 32'hDEAD_BEEF;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      total += 4;
      if (req_ready !== 1'b1) begin bad++; $display("FAIL midflight_req_ready c=%0d got=%b exp=1", c, req_ready); end
      if (mem_req_valid !== 1'b0) begin bad++; $display("FAIL midflight_mem_req_valid c=%0d got=%b exp=0", c, mem_req_valid); end
      if (rsp_valid !== 1'b0) begin bad++; $display("FAIL midflight_rsp_valid c=%0d got=%b exp=0", c, rsp_valid); end
      if (rsp_data !== 32'h0) begin bad++; $display("FAIL midflight_rsp_data c=%0d got=%h exp=0", c, rsp_data); end
      @(negedge clk);
    end
    mem_rsp_valid = 1'b0;
    run_load(32'($urandom_range(0, 'h1EF)), 2'd0, 1'b0, 1'b0, 0, d, l);
  endtask
  task automatic test_random;
    logic [31:0] d;
    int l;
    logic [1:0] sz;
    for (int i = 0; i < 150; i++) begin
      for (int j = 0; j < 4; j++) mem[$urandom_range(0, 511)] = 8'($urandom);
      sz = $urandom_range(0, 9) == 0 ? 2'd3 : 2'($urandom_range(0, 2));
      run_load(32'($urandom_range(0, 'h1EF)), sz, 1'($urandom), 1'($urandom), $urandom_range(0, 2), d, l);
    end
  endtask
  task automatic test_back_to_back;
    logic [31:0] d;
    int l;
    for (int i = 0; i < 20; i++) run_load(32'($urandom_range(0, 'h1EF)), 2'($urandom_range(0, 2)), 1'($urandom), 1'b1, 0, d, l);
  endtask
  initial begin
    total = 0;
    bad = 0;
    for (int i = 0; i < 512; i++) mem[i] = 8'($urandom);
    test_reset;
    test_directed;
    test_fault;
    test_hold;
    test_reset_midflight;
    test_random;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/load_align_unit.md
LOAD_ALIGN_UNIT -- requirements
Module: load_align_unit

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, giving the data width; legal values are 32 and 64.
REQ-002 The block SHALL have parameter ADDR_W, default 32, giving the byte-address width.
REQ-003 clk  in  1  the single clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 req_valid/req_ready  in/out  1/1  load request handshake.
REQ-006 req_addr  in  ADDR_W  byte address; req_size  in  2  encoding 0=byte, 1=half, 2=word, 3=double; req_unsigned  in  1  zero-extend when set.
REQ-007 mem_req_valid/mem_req_ready  out/in  1/1  memory read handshake; mem_req_addr  out  ADDR_W  always XLEN/8-aligned.
REQ-008 mem_rsp_valid  in  1; mem_rsp_data  in  XLEN  read data, one response per accepted memory request, in order.
REQ-009 rsp_valid/rsp_ready  out/in  1/1; rsp_data  out  XLEN; rsp_misaligned  out  1; rsp_fault  out  1.

Function
REQ-010 The block SHALL hold one load in flight; req_ready SHALL be 1 only in IDLE.
REQ-011 States SHALL be IDLE, REQ0, WAIT0, REQ1, WAIT1 and RESP.
REQ-012 IDLE->REQ0 on req_valid&&req_ready, capturing addr, size and unsigned; REQ0->WAIT0 on mem_req_valid&&mem_req_ready; WAIT0->RESP on mem_rsp_valid for a non-spanning access, ->REQ1 for a spanning one; REQ1->WAIT1 on memory handshake; WAIT1->RESP on mem_rsp_valid; RESP->IDLE on rsp_ready.
REQ-013 mem_req_valid SHALL be 1 only in REQ0 and REQ1; mem_req_addr SHALL be the aligned base in REQ0 and base+XLEN/8 in REQ1.
REQ-014 An access SHALL be spanning when (addr mod XLEN/8) + 2^size > XLEN/8.
REQ-015 Result SHALL be {beat1,beat0} shifted right by 8*(addr mod XLEN/8), truncated to 2^size bytes, and sign- or zero-extended to XLEN; beat1 SHALL be zero for non-spanning accesses.
REQ-016 rsp_valid SHALL be 1 only in RESP; rsp_data, rsp_misaligned and rsp_fault SHALL be stable while rsp_valid=1 and rsp_ready=0.
REQ-017 req_size=3 with XLEN=32 SHALL go IDLE->RESP directly with rsp_fault=1 and rsp_data=0, with no memory request.
REQ-018 With XLEN=32, req_unsigned with size 2 SHALL return the word unchanged; with XLEN=64 it SHALL zero-extend (lwu).
REQ-019 mem_rsp_valid outside WAIT0/WAIT1 SHALL be ignored.
REQ-020 Minimum aligned latency SHALL be 3 cycles from request accept to rsp_valid, with zero-wait memory.

Reset
REQ-021 rst SHALL force IDLE on the next edge from any state, abandoning any in-flight load.
REQ-022 During and after reset: req_ready=1 and mem_req_valid=0; rsp_valid, rsp_misaligned and rsp_fault SHALL be 0; rsp_data SHALL be 0; captured request registers SHALL be 0.

Configuration
REQ-023 Macro LOAD_MISALIGNED_SPLIT_EN defined: spanning accesses SHALL use two beats per REQ-012, with rsp_misaligned=0.
REQ-024 Macro undefined: a spanning access SHALL go IDLE->RESP with rsp_misaligned=1, rsp_data=0 and no memory request; REQ1 and WAIT1 SHALL be unreachable.

Structure
REQ-025 Package load_pkg SHALL hold the size encoding constants and the state enumeration.
REQ-026 Extraction and extension (REQ-015) SHALL be a combinational sub-module load_extend; the FSM, capture registers and beat buffers SHALL be in load_align_unit.

Verification
REQ-027 XLEN=32, lb at addr 0x103 with word 0x80FF_1234 -> rsp_data 0xFFFF_FF80.
REQ-028 lhu at 0x102 with word 0xBEEF_0000 -> rsp_data 0x0000_BEEF, 3 cycles after accept with zero-wait memory.
REQ-029 Macro defined: lw at 0x106 with beats 0x5566_7788 and 0x1122_3344 -> two memory requests, to 0x104 and 0x108, and rsp_data 0x3344_5566.
REQ-030 Macro undefined: the same lw at 0x106 -> rsp_misaligned=1 and no mem_req_valid.
REQ-031 rst asserted in WAIT1 -> IDLE next cycle; a later stray mem_rsp_valid is ignored; the next lb completes correctly.
REQ-032 rsp_ready held low 5 cycles in RESP -> rsp_data stable and req_ready=0 throughout.
